// File: rtl/tc_rn_seq.sv
// Job sequencer and per-lane accumulator around the tensor-core reduction network.
// Streams NK product vectors in, follows them through the fixed-latency trees with tags, emits one sum per job.
module tc_rn_seq #(
    parameter int unsigned N_ADT    = 4,
    parameter int unsigned TILE_K   = 8,
    parameter int unsigned DW_DATA  = 8,
    parameter int unsigned DW_ACC   = 24,
    parameter int unsigned TREE_LAT = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [CNT_W-1:0]                  cfg_nk,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_ADT*TILE_K*DW_DATA-1:0]   in_data,
    output logic [N_ADT*TILE_K*DW_DATA-1:0]   rn_in,
    input  logic [N_ADT*DW_DATA-1:0]          rn_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N_ADT*DW_ACC-1:0]           out_data,
    output logic                              busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } tag_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        nk, nk_nxt;
    logic [CNT_W-1:0]        issue_cnt, issue_nxt;
    tag_t [TREE_LAT-1:0]     tags, tags_nxt;
    tag_t                    push, exit_tag;
    logic [DW_ACC-1:0]       acc     [N_ADT];
    logic [DW_ACC-1:0]       acc_nxt [N_ADT];

    assign rn_in    = in_data;
    assign busy     = (state != IDLE);
    assign exit_tag = tags[TREE_LAT-1];

    // Tag pipe mirrors the tree pipeline; a single-stage pipe has nothing to shift.
    if (TREE_LAT == 1) begin : g_pipe1
        always_comb tags_nxt = push;
    end else begin : g_pipen
        always_comb tags_nxt = {tags[TREE_LAT-2:0], push};
    end

    always_comb begin
        state_nxt = state;
        nk_nxt    = nk;
        issue_nxt = issue_cnt;
        push      = '0;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    nk_nxt    = (cfg_nk == '0) ? CNT_W'(1) : cfg_nk;
                    issue_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = (issue_cnt < nk);
                if (in_valid && in_ready) begin
                    push.v     = 1'b1;
                    push.first = (issue_cnt == '0);
                    push.last  = (issue_cnt == nk - CNT_W'(1));
                    issue_nxt  = issue_cnt + CNT_W'(1);
                    if (push.last) state_nxt = DRAIN;
                end
            end
            DRAIN: ;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // The final chunk leaving the trees closes the job from either RUN or DRAIN.
        if (exit_tag.v && exit_tag.last) state_nxt = OUT;
    end

    always_comb begin
        for (int unsigned g = 0; g < N_ADT; g++) begin
            acc_nxt[g] = acc[g];
            if (exit_tag.v) begin
                if (exit_tag.first)
                    acc_nxt[g] = DW_ACC'($signed(rn_out[g*DW_DATA +: DW_DATA]));
                else
                    acc_nxt[g] = acc[g] + DW_ACC'($signed(rn_out[g*DW_DATA +: DW_DATA]));
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned g = 0; g < N_ADT; g++)
            out_data[g*DW_ACC +: DW_ACC] = acc[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            nk        <= '0;
            issue_cnt <= '0;
            tags      <= '0;
            for (int unsigned g = 0; g < N_ADT; g++)
                acc[g] <= '0;
        end else begin
            state     <= state_nxt;
            nk        <= nk_nxt;
            issue_cnt <= issue_nxt;
            tags      <= tags_nxt;
            for (int unsigned g = 0; g < N_ADT; g++)
                acc[g] <= acc_nxt[g];
        end
    end

endmodule

// File: tb/tb_tc_rn_seq.sv
// Bench for tc_rn_seq: table jobs, random jobs against an arithmetic reference, reset and narrow-accumulator cases.
module tb_tc_rn_seq;

    localparam int NA = 4;
    localparam int TK = 8;
    localparam int DD = 8;
    localparam int DA = 24;
    localparam int TL = 3;
    localparam int CW = 8;
    localparam int IW = NA*TK*DD;
    localparam int OW = NA*DA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cfg_valid, cfg_ready, in_valid, in_ready, out_valid, out_ready, busy;
    logic [CW-1:0] cfg_nk;
    logic [IW-1:0] in_data, rn_in;
    logic [NA*DD-1:0] rn_out;
    logic [OW-1:0] out_data;

    logic          c2_valid, c2_ready, i2_valid, i2_ready, o2_valid, o2_ready, busy2;
    logic [CW-1:0] c2_nk;
    logic [IW-1:0] i2_data, rn2_in;
    logic [NA*DD-1:0] rn2_out;
    logic [NA*8-1:0]  o2_data;

    tc_rn_seq u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_nk(cfg_nk),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rn_in(rn_in), .rn_out(rn_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    tc_rn_seq #(.DW_ACC(8), .TREE_LAT(1)) u_w8 (
        .clk(clk), .rst(rst), .cfg_valid(c2_valid), .cfg_ready(c2_ready), .cfg_nk(c2_nk),
        .in_valid(i2_valid), .in_ready(i2_ready), .in_data(i2_data), .rn_in(rn2_in), .rn_out(rn2_out),
        .out_valid(o2_valid), .out_ready(o2_ready), .out_data(o2_data), .busy(busy2)
    );

    int ncmp = 0;
    int nbad = 0;
    logic [IW-1:0] jobvec [256];

    function automatic logic [NA*DD-1:0] tree_sums(input logic [IW-1:0] x);
        logic [NA*DD-1:0] r;
        int s;
        r = '0;
        for (int g = 0; g < NA; g++) begin
            s = 0;
            for (int k = 0; k < TK; k++) s += int'($signed(x[(g*TK+k)*DD +: DD]));
            r[g*DD +: DD] = s[DD-1:0];
        end
        return r;
    endfunction

    // Reduction network stand-ins: fixed-latency, non-stalling, never reset.
    logic [NA*DD-1:0] npipe [TL];
    always @(posedge clk) begin
        npipe[0] <= tree_sums(rn_in);
        for (int i = 1; i < TL; i++) npipe[i] <= npipe[i-1];
    end
    assign rn_out = npipe[TL-1];
    always @(posedge clk) rn2_out <= tree_sums(rn2_in);

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] r;
        for (int i = 0; i < IW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [OW-1:0] ref_job(input int n);
        logic [OW-1:0] r;
        logic [NA*DD-1:0] t;
        longint a;
        r = '0;
        for (int g = 0; g < NA; g++) begin
            a = 0;
            for (int c = 0; c < n; c++) begin
                t = tree_sums(jobvec[c]);
                a += longint'($signed(t[g*DD +: DD]));
            end
            r[g*DA +: DA] = a[DA-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_job(input string name, input int nk_cfg, input int gap, input int hold,
                          input logic [OW-1:0] expv);
        int n, issued, gcnt, guard, lat, bad_busy, bad_cfg, bad_hold;
        logic [OW-1:0] snap;
        n = (nk_cfg == 0) ? 1 : nk_cfg;
        chk({name, " cfg_ready idle"}, OW'(cfg_ready), OW'(1));
        cfg_valid = 1'b1;
        cfg_nk    = nk_cfg[CW-1:0];
        @(negedge clk);
        cfg_nk = 8'($urandom);
        issued = 0; gcnt = 0; guard = 0; bad_busy = 0; bad_cfg = 0; bad_hold = 0;
        while (issued < n && guard < 4000) begin
            if (gcnt > 0) begin
                in_valid = 1'b0; in_data = rand_vec(); gcnt--;
            end else begin
                in_valid = 1'b1; in_data = jobvec[issued];
            end
            if (busy !== 1'b1) bad_busy++;
            if (cfg_ready !== 1'b0) bad_cfg++;
            if (in_valid && in_ready) begin
                issued++;
                gcnt = gap;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0; cfg_valid = 1'b0; in_data = rand_vec();
        chk({name, " handshakes"}, OW'(issued), OW'(n));
        chk({name, " in_ready after last"}, OW'(in_ready), OW'(0));
        chk({name, " busy/cfg_ready during issue"}, OW'(bad_busy + bad_cfg), OW'(0));
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        chk({name, " latency"}, OW'(lat), OW'(TL+1));
        snap = out_data;
        for (int h = 0; h < hold; h++) begin
            if (out_data !== snap || out_valid !== 1'b1 || cfg_ready !== 1'b0 || in_ready !== 1'b0)
                bad_hold++;
            @(negedge clk);
        end
        chk({name, " hold stable"}, OW'(bad_hold), OW'(0));
        chk({name, " result"}, out_data, expv);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " release {out_valid,busy,cfg_ready}"}, OW'({out_valid, busy, cfg_ready}), OW'(3'b001));
    endtask

    task automatic do_w8(input string name, input int nk_cfg, input logic [7:0] val, input logic [31:0] expv);
        int n, issued, guard, lat;
        logic [IW-1:0] v;
        n = (nk_cfg == 0) ? 1 : nk_cfg;
        v = '0;
        for (int g = 0; g < NA; g++) v[g*TK*DD +: DD] = val;
        c2_valid = 1'b1; c2_nk = nk_cfg[CW-1:0];
        @(negedge clk);
        c2_valid = 1'b0;
        issued = 0; guard = 0;
        while (issued < n && guard < 100) begin
            i2_valid = 1'b1; i2_data = v;
            if (i2_ready) issued++;
            @(negedge clk);
            guard++;
        end
        i2_valid = 1'b0; i2_data = rand_vec();
        lat = 1;
        while (o2_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, OW'(lat), OW'(2));
        chk({name, " result"}, OW'(o2_data), OW'(expv));
        o2_ready = 1'b1;
        @(negedge clk);
        o2_ready = 1'b0;
        chk({name, " released"}, OW'({o2_valid, c2_ready}), OW'(2'b01));
    endtask

    typedef struct packed {
        logic [7:0]             nk;
        logic [3:0]             gap;
        logic [3:0]             hold;
        logic [3:0][3:0][7:0]   v;
        logic [3:0][23:0]       exp;
    } row_t;

    row_t tbl [4];

    initial begin
        int n, nkc;
        logic [7:0] r8;

        tbl[0] = '0; tbl[0].nk = 8'd1; tbl[0].v[0] = {8'h80, 8'h7F, 8'hFF, 8'h01};
        tbl[0].exp = {24'hFFFF80, 24'h00007F, 24'hFFFFFF, 24'h000001};
        tbl[1] = '0; tbl[1].nk = 8'd4; tbl[1].hold = 4'd10;
        for (int c = 0; c < 4; c++) tbl[1].v[c] = {4{8'd100}};
        tbl[1].exp = {4{24'd400}};
        tbl[2] = '0; tbl[2].nk = 8'd3; tbl[2].gap = 4'd2; tbl[2].hold = 4'd1;
        tbl[2].v[0] = {4{8'h05}}; tbl[2].v[1] = {4{8'hF9}}; tbl[2].v[2] = {4{8'h09}};
        tbl[2].exp = {4{24'd7}};
        tbl[3] = '0; tbl[3].nk = 8'd0; tbl[3].gap = 4'd1; tbl[3].v[0] = {8'hCE, 8'h32, 8'hFC, 8'h03};
        tbl[3].exp = {24'hFFFFCE, 24'h000032, 24'hFFFFFC, 24'h000003};

        rst = 1'b1;
        cfg_valid = 1'b0; cfg_nk = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        c2_valid = 1'b0; c2_nk = '0; i2_valid = 1'b0; i2_data = '0; o2_ready = 1'b0;
        @(negedge clk);
        chk("reset {cfg_ready,in_ready,out_valid,busy}", OW'({cfg_ready, in_ready, out_valid, busy}), OW'(4'b1000));
        chk("reset out_data", out_data, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) begin
                jobvec[c] = '0;
                for (int g = 0; g < NA; g++) begin
                    r8 = 8'($urandom_range(0, 100));
                    jobvec[c][(g*TK)*DD +: DD]   = tbl[i].v[c][g];
                    jobvec[c][(g*TK+1)*DD +: DD] = r8;
                    jobvec[c][(g*TK+2)*DD +: DD] = -r8;
                end
            end
            do_job($sformatf("tbl%0d", i), int'(tbl[i].nk), int'(tbl[i].gap), int'(tbl[i].hold), tbl[i].exp);
        end

        for (int j = 0; j < 20; j++) begin
            n = $urandom_range(1, 6);
            nkc = (n == 1 && $urandom_range(0, 1) == 1) ? 0 : n;
            for (int c = 0; c < n; c++) jobvec[c] = rand_vec();
            do_job($sformatf("rnd%0d", j), nkc, $urandom_range(0, 2), $urandom_range(0, 3), ref_job(n));
        end

        for (int c = 0; c < 255; c++) jobvec[c] = rand_vec();
        do_job("nk255", 255, 0, 0, ref_job(255));

        // Abort a job with two chunks inside the trees.
        for (int c = 0; c < 2; c++) begin
            jobvec[c] = '0;
            for (int g = 0; g < NA; g++) jobvec[c][g*TK*DD +: DD] = 8'd50;
        end
        cfg_valid = 1'b1; cfg_nk = 8'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_data = jobvec[c];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst {cfg_ready,in_ready,out_valid,busy}", OW'({cfg_ready, in_ready, out_valid, busy}), OW'(4'b1000));
        chk("midrst out_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        jobvec[0] = '0;
        for (int g = 0; g < NA; g++) jobvec[0][g*TK*DD +: DD] = 8'(10*(g+1));
        do_job("after_rst", 1, 0, 0, {24'd40, 24'd30, 24'd20, 24'd10});

        do_w8("w8_wrap", 3, 8'd127, {4{8'h7D}});
        do_w8("w8_nk1", 1, 8'h85, {4{8'h85}});
        do_w8("w8_zero", 2, 8'h80, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
